// File: rtl/row_feeder.sv
// row_feeder: drains the raster-order pixel FIFO into the three row FIFOs
// that feed the 3x3 window stage. Writes are staggered by row so that one
// pop from each row FIFO yields a vertically aligned 3-pixel column.
// Emits a one-cycle frame_done pulse after the final pixel of each frame.
module row_feeder #(
  parameter int IMG_HEIGHT = 720,
  parameter int IMG_WIDTH  = 540
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       row_1_wr_en,
  input  logic       row_1_full,
  output logic [7:0] row_1_din,
  output logic       row_2_wr_en,
  input  logic       row_2_full,
  output logic [7:0] row_2_din,
  output logic       row_3_wr_en,
  input  logic       row_3_full,
  output logic [7:0] row_3_din,
  output logic       frame_done
);

  // Counter widths; clamp to one bit so a single-column image still elaborates
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_T1   = RW'(IMG_HEIGHT - 3);
  localparam logic [RW-1:0] ROW_T2   = RW'(IMG_HEIGHT - 2);
  localparam logic [RW-1:0] ROW_T3   = RW'(2);

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_DONE   = 2'd1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic w_t1;
  logic w_t2;
  logic w_t3;
  logic w_blocked;
  logic w_xfer;
  logic w_col_last;
  logic w_last_pix;

  // Target mask and transfer qualification from the registered row position
  always_comb begin
    w_t1       = (r_row <= ROW_T1);
    w_t2       = (r_row != '0) && (r_row <= ROW_T2);
    w_t3       = (r_row >= ROW_T3);
    // only a full FIFO that this pixel targets may hold the pixel back
    w_blocked  = (w_t1 && row_1_full) || (w_t2 && row_2_full) || (w_t3 && row_3_full);
    // reset gates the transfer so outputs stay quiet while reset is held
    w_xfer     = reset && (r_state == ST_STREAM) && !in_empty && !w_blocked;
    w_col_last = (r_col == COL_LAST);
    w_last_pix = w_col_last && (r_row == ROW_LAST);
  end

  // Raster position counters, advanced once per transferred pixel
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_xfer) begin
      if (w_col_last) begin
        r_col <= '0;
        if (r_row == ROW_LAST) r_row <= '0;
        else                   r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_STREAM;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: one DONE bubble after the final pixel of a frame
  always_comb begin
    w_state_nxt = ST_STREAM;
    case (r_state)
      ST_STREAM: if (w_xfer && w_last_pix) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_STREAM;
      default:   w_state_nxt = ST_STREAM;
    endcase
  end

  // Output decode: zero-latency pass-through of the head pixel to targeted FIFOs
  always_comb begin
    in_rd_en    = 1'b0;
    row_1_wr_en = 1'b0;
    row_2_wr_en = 1'b0;
    row_3_wr_en = 1'b0;
    row_1_din   = '0;
    row_2_din   = '0;
    row_3_din   = '0;
    frame_done  = 1'b0;
    case (r_state)
      ST_STREAM: begin
        if (w_xfer) begin
          in_rd_en    = 1'b1;
          row_1_wr_en = w_t1;
          row_2_wr_en = w_t2;
          row_3_wr_en = w_t3;
          row_1_din   = w_t1 ? in_dout : '0;
          row_2_din   = w_t2 ? in_dout : '0;
          row_3_din   = w_t3 ? in_dout : '0;
        end
      end
      ST_DONE:  frame_done = reset;
      default:  frame_done = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_row_feeder.sv
// Directed bench for row_feeder at IMG_WIDTH=4, IMG_HEIGHT=5, pixel = 16*r+c.
// Expected row-FIFO contents are queued when pixels are loaded into the input
// FIFO model and popped as the DUT writes; a small position model predicts
// strobes and frame_done every cycle.
module tb_row_feeder;

  localparam int W = 4;
  localparam int H = 5;

  logic       clock;
  logic       reset;
  logic       in_rd_en;
  logic       in_empty;
  logic [7:0] in_dout;
  logic       row_1_wr_en, row_2_wr_en, row_3_wr_en;
  logic       row_1_full,  row_2_full,  row_3_full;
  logic [7:0] row_1_din,   row_2_din,   row_3_din;
  logic       frame_done;

  row_feeder #(.IMG_HEIGHT(H), .IMG_WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_rd_en    (in_rd_en),
    .in_empty    (in_empty),
    .in_dout     (in_dout),
    .row_1_wr_en (row_1_wr_en),
    .row_1_full  (row_1_full),
    .row_1_din   (row_1_din),
    .row_2_wr_en (row_2_wr_en),
    .row_2_full  (row_2_full),
    .row_2_din   (row_2_din),
    .row_3_wr_en (row_3_wr_en),
    .row_3_full  (row_3_full),
    .row_3_din   (row_3_din),
    .frame_done  (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  logic [7:0] inq[$];
  logic [7:0] exp1[$];
  logic [7:0] exp2[$];
  logic [7:0] exp3[$];

  logic gate_empty = 1'b0;
  int   m_row = 0;
  int   m_col = 0;
  logic m_done = 1'b0;

  int   n_wr1, n_wr2, n_wr3, n_done;
  logic       s_rd;
  logic [2:0] s_wr;
  logic [7:0] s_din1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // push n pixels of a frame (raster order) and their expected row-FIFO targets
  task automatic load_frame(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      logic [7:0] p;
      r = i / W;
      p = 8'((r << 4) + (i % W));
      inq.push_back(p);
      if (r <= H - 3)          exp1.push_back(p);
      if (r >= 1 && r <= H - 2) exp2.push_back(p);
      if (r >= 2)              exp3.push_back(p);
    end
  endtask

  task automatic sb_check(input string tag, input logic wr, input logic [7:0] din,
                          inout logic [7:0] q[$], inout int cnt);
    if (wr) begin
      cnt++;
      if (q.size() == 0) chk({tag, "_unexpected_write"}, 32'(din), 32'hFFFF_FFFF);
      else               chk({tag, "_data"}, 32'(din), 32'(q.pop_front()));
    end else begin
      chk({tag, "_idle_zero"}, 32'(din), 32'h0);
    end
  endtask

  // one clock: drive inputs, check at negedge against the model, then advance
  task automatic cycle();
    logic t1, t2, t3, mx;
    in_empty = gate_empty || (inq.size() == 0);
    in_dout  = (inq.size() != 0) ? inq[0] : 8'h00;
    @(negedge clock);
    t1 = (m_row <= H - 3);
    t2 = (m_row >= 1) && (m_row <= H - 2);
    t3 = (m_row >= 2);
    mx = reset && !m_done && !in_empty &&
         !(t1 && row_1_full) && !(t2 && row_2_full) && !(t3 && row_3_full);
    s_rd   = in_rd_en;
    s_wr   = {row_3_wr_en, row_2_wr_en, row_1_wr_en};
    s_din1 = row_1_din;
    chk("in_rd_en",    32'(in_rd_en),    32'(mx));
    chk("row_1_wr_en", 32'(row_1_wr_en), 32'(mx && t1));
    chk("row_2_wr_en", 32'(row_2_wr_en), 32'(mx && t2));
    chk("row_3_wr_en", 32'(row_3_wr_en), 32'(mx && t3));
    chk("frame_done",  32'(frame_done),  32'(reset && m_done));
    sb_check("row1", row_1_wr_en, row_1_din, exp1, n_wr1);
    sb_check("row2", row_2_wr_en, row_2_din, exp2, n_wr2);
    sb_check("row3", row_3_wr_en, row_3_din, exp3, n_wr3);
    if (frame_done) n_done++;
    @(posedge clock);
    if (!reset) begin
      m_row = 0; m_col = 0; m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (mx) begin
      void'(inq.pop_front());
      if (m_col == W - 1) begin
        m_col = 0;
        if (m_row == H - 1) begin m_row = 0; m_done = 1'b1; end
        else m_row++;
      end else m_col++;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counts();
    n_wr1 = 0; n_wr2 = 0; n_wr3 = 0; n_done = 0;
  endtask

  task automatic drained(input string tag);
    chk({tag, "_inq_empty"},  32'(inq.size()),  32'h0);
    chk({tag, "_exp1_empty"}, 32'(exp1.size()), 32'h0);
    chk({tag, "_exp2_empty"}, 32'(exp2.size()), 32'h0);
    chk({tag, "_exp3_empty"}, 32'(exp3.size()), 32'h0);
  endtask

  initial begin
    reset = 1'b0; in_empty = 1'b1; in_dout = 8'h00;
    row_1_full = 1'b0; row_2_full = 1'b0; row_3_full = 1'b0;
    clear_counts();
    #1;
    run(2);
    chk("reset_rd_en", 32'(s_rd), 32'h0);
    reset = 1'b1;
    run(2);

    // free-flowing frame
    clear_counts();
    load_frame(W * H);
    run(25);
    chk("free_wr1_count", 32'(n_wr1), 32'd12);
    chk("free_wr2_count", 32'(n_wr2), 32'd12);
    chk("free_wr3_count", 32'(n_wr3), 32'd12);
    chk("free_done_count", 32'(n_done), 32'd1);
    drained("free");

    // untargeted full during row 0 does not stall
    clear_counts();
    load_frame(W * H);
    row_3_full = 1'b1;
    run(W);
    chk("r3full_row0_consumed", 32'(inq.size()), 32'(W * H - W));
    chk("r3full_row0_wr1", 32'(n_wr1), 32'(W));
    chk("r3full_row0_wr3", 32'(n_wr3), 32'd0);
    row_3_full = 1'b0;
    run(20);
    chk("r3full_done_count", 32'(n_done), 32'd1);
    drained("r3full");

    // targeted full at row 2 col 1 stalls everything
    clear_counts();
    load_frame(W * H);
    run(9);
    row_3_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_rd_en", 32'(s_rd), 32'h0);
      chk("stall_wr_en", 32'(s_wr), 32'h0);
    end
    row_3_full = 1'b0;
    cycle();
    chk("stall_release_wr", 32'(s_wr), 32'h7);
    chk("stall_release_din", 32'(s_din1), 32'h21);
    run(15);
    chk("stall_done_count", 32'(n_done), 32'd1);
    drained("stall");

    // in_empty toggled every other cycle over two back-to-back frames
    clear_counts();
    load_frame(W * H);
    load_frame(W * H);
    for (int i = 0; i < 90; i++) begin
      gate_empty = i[0];
      cycle();
    end
    gate_empty = 1'b0;
    chk("toggle_done_count", 32'(n_done), 32'd2);
    chk("toggle_wr1_count", 32'(n_wr1), 32'd24);
    drained("toggle");

    // reset mid-frame after 6 pixels
    clear_counts();
    load_frame(6);
    run(6);
    chk("midrst_pre_consumed", 32'(inq.size()), 32'h0);
    load_frame(W * H);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("midrst_rd_en", 32'(s_rd), 32'h0);
      chk("midrst_wr_en", 32'(s_wr), 32'h0);
    end
    reset = 1'b1;
    cycle();
    chk("midrst_first_wr", 32'(s_wr), 32'h1);
    chk("midrst_first_din", 32'(s_din1), 32'h00);
    n_done = 0;
    run(19);
    chk("midrst_done_early", 32'(n_done), 32'd0);
    cycle();
    chk("midrst_done_after_20", 32'(n_done), 32'd1);
    run(3);
    drained("midrst");

    // row_2_full drops in the same cycle a row-1 pixel is presented
    clear_counts();
    load_frame(W * H);
    row_2_full = 1'b1;
    run(W);
    cycle();
    chk("r2full_stall_rd", 32'(s_rd), 32'h0);
    row_2_full = 1'b0;
    cycle();
    chk("r2full_release_rd", 32'(s_rd), 32'h1);
    chk("r2full_release_wr", 32'(s_wr), 32'h3);
    chk("r2full_release_din", 32'(s_din1), 32'h10);
    run(20);
    chk("r2full_done_count", 32'(n_done), 32'd1);
    drained("r2full");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/row_feeder.md
# row_feeder

Front end of the edge-detection datapath. It drains the incoming 8-bit grayscale pixel stream from the input FIFO in raster order and writes each pixel into the three row FIFOs consumed by the 3x3 window stage. The writes are staggered so that FIFO k holds image rows k-1 .. IMG_HEIGHT-4+k. As a result, one pop from each row FIFO yields a vertically aligned 3-pixel column. It is the producer side of the row-FIFO interface, and it emits a frame-boundary pulse.

## Interface
Parameters:
- IMG_HEIGHT, 720, image rows per frame; must be >= 3
- IMG_WIDTH, 540, pixels per row; must be >= 1

Ports (one clock; reset is synchronous and active-low):
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- in_rd_en  out  1  pop from input pixel FIFO (first-word-fall-through)
- in_empty  in  1  input FIFO empty
- in_dout  in  8  current head pixel of input FIFO
- row_1_wr_en  out  1  write strobe, row FIFO 1 (top row of window)
- row_1_full  in  1  row FIFO 1 full
- row_1_din  out  8  write data, row FIFO 1
- row_2_wr_en / row_2_full / row_2_din  same as above, row FIFO 2 (middle row)
- row_3_wr_en / row_3_full / row_3_din  same as above, row FIFO 3 (bottom row)
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written

## Operation
- Counters:
  - col: $clog2(IMG_WIDTH) bits.
  - row: $clog2(IMG_HEIGHT) bits.
  - Both reset to 0.
- Target mask for the current pixel (row r):
  - t1 = (r <= IMG_HEIGHT-3)
  - t2 = (1 <= r <= IMG_HEIGHT-2)
  - t3 = (r >= 2)
  - Decoded combinationally from the registered row counter.
- Transfer condition: xfer = (state==STREAM) && !in_empty && for every k with tk set, !row_k_full.
- When xfer is true:
  - in_rd_en = 1.
  - row_k_wr_en = tk.
  - row_k_din = in_dout for targeted k.
- Untargeted FIFOs and non-transfer cycles:
  - wr_en = 0.
  - din = 8'h00.
- Writes are all-or-nothing. A full targeted FIFO stalls the pixel for all FIFOs. A full untargeted FIFO does not stall.
- Counter update on xfer:
  - col increments.
  - At col==IMG_WIDTH-1: col wraps to 0 and row increments.
  - At the last pixel (row==IMG_HEIGHT-1, col==IMG_WIDTH-1): both counters wrap to 0.
- State machine:
  - STREAM: transfers permitted. On xfer of the last pixel of a frame, go to DONE.
  - DONE: frame_done=1 and no transfer (in_rd_en=0, all wr_en=0). Unconditionally return to STREAM next cycle.
  - Unused encodings go to STREAM.
- Per frame, each row FIFO receives exactly (IMG_HEIGHT-2)*IMG_WIDTH pixels, and the input FIFO is popped exactly IMG_HEIGHT*IMG_WIDTH times.
- Row FIFO 1 runs two rows ahead of row FIFO 3. Row FIFOs 1 and 2 must have depth >= 2*IMG_WIDTH+1 and >= IMG_WIDTH+1 respectively, or the pipeline deadlocks. This is an integration requirement; the block does not check it.

## Timing
- Reset (reset==0 at a rising edge):
  - state=STREAM, row=0, col=0.
  - All outputs low/zero.
  - Reset mid-frame discards the frame position. The next transferred pixel is treated as row 0, col 0; pixels already written stay in the FIFOs.
- Datapath is zero-latency combinational: in_dout to row_k_din, and in_empty/full to in_rd_en/wr_en, in the same cycle.
- Throughput: 1 pixel/cycle sustained while no stall, except the single DONE bubble per frame.
- frame_done is asserted in the cycle after the final xfer and lasts exactly one cycle.
- Flags are sampled only in the transfer cycle. A full flag deasserting in the same cycle allows the transfer.
- in_empty and a targeted full in the same cycle give no transfer and leave counters unchanged.

## Test plan
Directed tests run with IMG_WIDTH=4, IMG_HEIGHT=5 and pixel value 16*r+c.
- Free-flowing frame of 20 pixels, no full flags:
  - FIFO1 gets 0x00..0x23 (rows 0-2), FIFO2 gets 0x10..0x33, FIFO3 gets 0x20..0x43, 12 writes each.
  - frame_done pulses once, in cycle 21.
- row_3_full held high during row 0:
  - No stall; 4 pixels flow to FIFO1 only.
- row_3_full held high for 3 cycles during row 2 col 1:
  - in_rd_en and all wr_en are 0 for 3 cycles.
  - Pixel 0x21 is then written to all three FIFOs in one cycle.
- in_empty toggled every other cycle over 2 back-to-back frames:
  - Ordering is preserved, and frame_done pulses twice.
  - Second-frame pixel 0x00 is written to FIFO1 only, and no transfer occurs in either DONE cycle.
- Reset asserted after 6 pixels, then a full 20-pixel frame supplied:
  - Outputs are zero during reset.
  - The first post-reset pixel goes to FIFO1 only (row 0).
  - frame_done follows the 20th post-reset pixel.
- Simultaneous in_empty=0, row_2_full deasserting in the same cycle as a row-1 pixel:
  - The transfer occurs that cycle (t1, t2 set; t3 clear).
